// File: rtl/triangle_rasterizer_pkg.sv
// Shared types and widths for the triangle rasterizer.
//   CW      : coordinate width (unsigned coordinates)
//   AW      : signed area accumulator width, wide enough for six CWxCW products
//   state_e : controller states
//   point_t : packed {x, y} coordinate pair
package triangle_rasterizer_pkg;

  localparam int unsigned CW = 12;
  localparam int unsigned AW = 2 * CW + 4;
  localparam int unsigned NW = 2 * CW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } point_t;

  // Smallest of three unsigned coordinates.
  function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  // Largest of three unsigned coordinates.
  function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tri_area.sv
// Combinational signed area term E(P,Q,R) = Py*Qx - Px*Qy + Px*Ry - Py*Rx + Qy*Rx - Qx*Ry.
// Positive when P, Q, R wind the same way as a properly oriented triangle.
//   p, q, r : input points
//   area_c  : AW-bit signed result
module tri_area
  import triangle_rasterizer_pkg::*;
(
  input  point_t                p,
  input  point_t                q,
  input  point_t                r,
  output logic signed [AW-1:0] area_c
);

  // Unsigned product zero-extended to AW; the sum is done modulo 2^AW and cannot overflow.
  function automatic logic [AW-1:0] mul(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return AW'(a) * AW'(b);
  endfunction

  always_comb begin
    area_c = signed'(mul(p.y, q.x) - mul(p.x, q.y) + mul(p.x, r.y)
                   - mul(p.y, r.x) + mul(q.y, r.x) - mul(q.x, r.y));
  end

endmodule

// File: rtl/triangle_rasterizer.sv
// Scans a triangle's bounding box one candidate per cycle and streams every integer
// point strictly inside the triangle over a valid/ready output.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : one-cycle request, vertices sampled when idle
//   ax..cy             : triangle vertices
//   busy               : high from accepted start until done
//   out_valid/out_ready: output handshake for px/py
//   done               : one-cycle completion pulse
//   count              : points emitted for the last or current triangle
module triangle_rasterizer
  import triangle_rasterizer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] ax,
  input  logic [CW-1:0] ay,
  input  logic [CW-1:0] bx,
  input  logic [CW-1:0] by,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          done,
  output logic [NW-1:0] count
);

  state_e        state_q, state_d;
  point_t        a_q, a_d, b_q, b_d, c_q, c_d;
  point_t        cur_q, cur_d;
  logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [CW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [NW-1:0] count_q, count_d;

  logic signed [AW-1:0] e0_c, e1_c, e2_c;
  logic                 inside_c;
  logic                 slot_free_c;

  // The three edge tests: cursor substituted for A, B and C in turn.
  tri_area u_e0 (.p(cur_q), .q(b_q),   .r(c_q),   .area_c(e0_c));
  tri_area u_e1 (.p(a_q),   .q(cur_q), .r(c_q),   .area_c(e1_c));
  tri_area u_e2 (.p(a_q),   .q(b_q),   .r(cur_q), .area_c(e2_c));

  // Strictly positive on all three edges; boundary points (zero area) are rejected.
  always_comb begin
    inside_c = !e0_c[AW-1] && (|e0_c) &&
               !e1_c[AW-1] && (|e1_c) &&
               !e2_c[AW-1] && (|e2_c);
  end

  // Output slot can take a new point if empty or being drained this cycle.
  always_comb begin
    slot_free_c = !out_valid_q || out_ready;
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    cur_d       = cur_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    px_d        = px_q;
    py_d        = py_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    count_d     = count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // done_q marks the cycle right after completion; a start there is ignored.
        if (start && !done_q) begin
          a_d     = '{x: ax, y: ay};
          b_d     = '{x: bx, y: by};
          c_d     = '{x: cx, y: cy};
          count_d = '0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end

      SETUP: begin
        xmin_d  = min3(a_q.x, b_q.x, c_q.x);
        xmax_d  = max3(a_q.x, b_q.x, c_q.x);
        ymin_d  = min3(a_q.y, b_q.y, c_q.y);
        ymax_d  = max3(a_q.y, b_q.y, c_q.y);
        cur_d   = '{x: min3(a_q.x, b_q.x, c_q.x), y: min3(a_q.y, b_q.y, c_q.y)};
        state_d = SCAN;
      end

      SCAN: begin
        if (slot_free_c) begin
          if (inside_c) begin
            px_d        = cur_q.x;
            py_d        = cur_q.y;
            out_valid_d = 1'b1;
            count_d     = count_q + NW'(1);
          end
          // Compare before incrementing so a box edge at 2^CW-1 never wraps.
          if (cur_q.x == xmax_q) begin
            cur_d.x = xmin_q;
            if (cur_q.y == ymax_q) begin
              state_d = DRAIN;
            end else begin
              cur_d.y = cur_q.y + CW'(1);
            end
          end else begin
            cur_d.x = cur_q.x + CW'(1);
          end
        end
      end

      DRAIN: begin
        if (slot_free_c) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cur_q       <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      px_q        <= '0;
      py_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cur_q       <= cur_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      px_q        <= px_d;
      py_q        <= py_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign px        = px_q;
  assign py        = py_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed testbench for triangle_rasterizer.
module tb_triangle_rasterizer;
  import triangle_rasterizer_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] ax, ay, bx, by, cx, cy;
  logic          busy, out_valid, out_ready, done;
  logic [CW-1:0] px, py;
  logic [NW-1:0] count;

  int tests = 0;
  int fails = 0;

  int unsigned edge_cnt = 0;
  int unsigned n_edge;

  int  qx[$];
  int  qy[$];
  bit  valid_seen, done_seen;
  int  lat;
  int  stall_bad;
  int  busy_after;

  triangle_rasterizer dut (
    .clk(clk), .rst(rst), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .px(px), .py(py), .done(done), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference area function with wide signed arithmetic.
  function automatic longint e_m(input longint p_x, input longint p_y, input longint q_x,
                                 input longint q_y, input longint r_x, input longint r_y);
    return p_y*q_x - p_x*q_y + p_x*r_y - p_y*r_x + q_y*r_x - q_x*r_y;
  endfunction

  function automatic bit inside_m(input longint a_x, input longint a_y, input longint b_x,
                                  input longint b_y, input longint c_x, input longint c_y,
                                  input longint p_x, input longint p_y);
    return (e_m(p_x, p_y, b_x, b_y, c_x, c_y) > 0) &&
           (e_m(a_x, a_y, p_x, p_y, c_x, c_y) > 0) &&
           (e_m(a_x, a_y, b_x, b_y, p_x, p_y) > 0);
  endfunction

  // Start one triangle and collect handshaked points until done or budget expires.
  // stall: cycles of out_ready=0 once the first point is valid; poke: pulse start mid-stall.
  task automatic run_tri(input int a_x, input int a_y, input int b_x, input int b_y,
                         input int c_x, input int c_y, input int stall, input bit poke,
                         input int budget);
    int  stall_left;
    bit  hold_set;
    int  hx, hy;
    qx.delete();
    qy.delete();
    valid_seen = 1'b0;
    done_seen  = 1'b0;
    stall_bad  = 0;
    lat        = -1;
    busy_after = 0;
    stall_left = stall;
    hold_set   = 1'b0;
    hx = 0;
    hy = 0;
    @(negedge clk);
    ax = CW'(a_x); ay = CW'(a_y);
    bx = CW'(b_x); by = CW'(b_y);
    cx = CW'(c_x); cy = CW'(c_y);
    start     = 1'b1;
    out_ready = 1'b1;
    n_edge    = edge_cnt + 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) busy_after = int'(busy);
      if (out_valid) valid_seen = 1'b1;
      if (done) begin
        done_seen = 1'b1;
        lat = int'(edge_cnt - n_edge);
        break;
      end
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        if (hold_set) begin
          if (int'(px) != hx || int'(py) != hy) stall_bad++;
        end else begin
          hold_set = 1'b1;
          hx = int'(px);
          hy = int'(py);
        end
        if (poke && stall_left == 3) begin
          ax = CW'(0); ay = CW'(0);
          bx = CW'(0); by = CW'(9);
          cx = CW'(9); cy = CW'(0);
          start = 1'b1;
        end
        stall_left--;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          qx.push_back(int'(px));
          qy.push_back(int'(py));
        end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic check_tri1(input string tag);
    check({tag, " npts"}, longint'(qx.size()), 3);
    if (qx.size() == 3) begin
      check({tag, " p0"}, longint'(qx[0] * 10000 + qy[0]), 10001);
      check({tag, " p1"}, longint'(qx[1] * 10000 + qy[1]), 20001);
      check({tag, " p2"}, longint'(qx[2] * 10000 + qy[2]), 10002);
    end
    check({tag, " count"}, longint'(count), 3);
  endtask

  initial begin
    int bad;
    int got;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst busy", longint'(busy), 0);
    check("rst out_valid", longint'(out_valid), 0);
    check("rst px", longint'(px), 0);
    check("rst py", longint'(py), 0);
    check("rst done", longint'(done), 0);
    check("rst count", longint'(count), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic triangle, no backpressure
    run_tri(0, 0, 0, 4, 4, 0, 0, 1'b0, 200);
    check("t1 busy after start", longint'(busy_after), 1);
    check("t1 done seen", longint'(done_seen), 1);
    check("t1 done latency", longint'(lat), 27);
    check("t1 busy at done", longint'(busy), 0);
    check_tri1("t1");
    @(negedge clk);
    check("t1 done one cycle", longint'(done), 0);

    // Reversed winding
    run_tri(0, 0, 4, 0, 0, 4, 0, 1'b0, 200);
    check("t2 valid seen", longint'(valid_seen), 0);
    check("t2 count", longint'(count), 0);
    check("t2 done seen", longint'(done_seen), 1);

    // Collinear
    run_tri(0, 0, 2, 2, 4, 4, 0, 1'b0, 200);
    check("t3 valid seen", longint'(valid_seen), 0);
    check("t3 count", longint'(count), 0);
    check("t3 done seen", longint'(done_seen), 1);

    // Degenerate single-point box
    run_tri(7, 7, 7, 7, 7, 7, 0, 1'b0, 50);
    check("t4 valid seen", longint'(valid_seen), 0);
    check("t4 count", longint'(count), 0);
    check("t4 done latency", longint'(lat), 3);

    // Box touching the coordinate maximum: x=4094, y=2048..4094 are inside
    run_tri(4095, 0, 4093, 4095, 4095, 4095, 0, 1'b0, 20000);
    check("t5 done seen", longint'(done_seen), 1);
    check("t5 done latency", longint'(lat), 3 * 4096 + 2);
    check("t5 npts", longint'(qx.size()), 2047);
    check("t5 count", longint'(count), 2047);
    bad = 0;
    for (int i = 0; i < qx.size(); i++) begin
      if (!inside_m(4095, 0, 4093, 4095, 4095, 4095, qx[i], qy[i])) bad++;
    end
    check("t5 model outside points", longint'(bad), 0);
    if (qx.size() > 0) begin
      check("t5 first", longint'(qx[0] * 10000 + qy[0]), 40942048);
      got = qx.size() - 1;
      check("t5 last", longint'(qx[got] * 10000 + qy[got]), 40944094);
    end

    // Backpressure on the first point, plus a start pulse while busy
    run_tri(0, 0, 0, 4, 4, 0, 5, 1'b1, 300);
    check("t6 done seen", longint'(done_seen), 1);
    check("t6 stall unstable", longint'(stall_bad), 0);
    check_tri1("t6");

    // Reset in the middle of a scan, while a point is held
    @(negedge clk);
    ax = CW'(0); ay = CW'(0); bx = CW'(0); by = CW'(4); cx = CW'(4); cy = CW'(0);
    start = 1'b1;
    out_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    check("t7 valid before reset", longint'(got), 1);
    rst = 1'b1;
    #1;
    check("t7 busy", longint'(busy), 0);
    check("t7 out_valid", longint'(out_valid), 0);
    check("t7 count", longint'(count), 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) bad++;
    end
    check("t7 no done", longint'(bad), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Normal run after the abort
    run_tri(0, 0, 0, 4, 4, 0, 0, 1'b0, 200);
    check("t8 done latency", longint'(lat), 27);
    check_tri1("t8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/triangle_rasterizer.md
# triangle_rasterizer

- Sequential counterpart of the combinational point-in-triangle test: the test answers whether one given point P lies inside triangle ABC; this block takes a triangle and produces every integer point strictly inside it.
- Scans the triangle's bounding box one candidate per cycle and evaluates the same three signed-area tests.
- Streams accepted points out over a valid/ready interface.
- Sits between the vertex source and any per-pixel consumer, e.g. the result writer.

## Interface
Parameters:
- CW, 12: coordinate width, unsigned.
- AW, 2*CW+4 (28): signed area accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; samples vertices; ignored unless idle.
- ax, ay, bx, by, cx, cy  in  CW each  triangle vertices.
- busy  out  1  high from accepted start until done.
- out_valid  out  1  px/py hold an inside point.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- px, py  out  CW each  emitted point.
- done  out  1  one-cycle pulse when a triangle completes.
- count  out  2*CW+1  number of points emitted for the last or current triangle.

## Operation
Area function E(P,Q,R) = Py*Qx − Px*Qy + Px*Ry − Py*Rx + Qy*Rx − Qx*Ry:
- Each product is CW×CW unsigned, zero-extended to AW, then sign-interpreted.
- Sum is AW-bit signed and cannot overflow.

Inside test:
- Candidate P is inside iff E(P,B,C) > 0, E(A,P,C) > 0 and E(A,B,P) > 0, all strict.
- Boundary points are not emitted.
- Reversed winding or collinear vertices emit zero points.

States:
- IDLE: start registers the vertices, clears count and moves to SETUP.
- SETUP, one cycle: xmin/xmax/ymin/ymax = min/max over the three vertices. Cursor set to (xmin, ymin). Go to SCAN.
- SCAN: each cycle in which the output slot is free or being drained, evaluate the cursor and advance it.
  - Scan order: x increments first; at x == xmax, x returns to xmin and y increments.
  - An inside candidate loads px/py, sets out_valid and increments count.
  - After evaluating (xmax, ymax), go to DRAIN.
- DRAIN: wait until out_valid is clear (or clears this cycle), then pulse done, drop busy and return to IDLE.

Rules:
- Compare the cursor against the max before incrementing so xmax = ymax = 2^CW−1 never wraps.
- The output slot is a single register. The cursor stalls only while out_valid && !out_ready.
- px/py/out_valid are stable while stalled.

## Timing
- Reset values: busy=0, out_valid=0, px=py=0, done=0, count=0, state IDLE.
- Reset asserted mid-scan aborts immediately: no done pulse, count cleared.
- start accepted at edge n → busy=1 after n. SETUP occupies edge n+1. First candidate is evaluated at edge n+2, so out_valid can be high from n+2.
- Without backpressure, a box of W×H candidates finishes evaluation at edge n+1+W*H. done is high for the cycle after the final output handshake, or after the last evaluation if nothing is pending.
- start coincident with done/DRAIN is ignored. start in the same cycle as reset is lost.
- Single-point box (all vertices equal): one candidate, zero output, done at n+3.

## Structure
- Shared package holds: CW, AW, state enum (IDLE, SETUP, SCAN, DRAIN), and point struct {x, y}.
- One sub-module: tri_area, purely combinational E(P,Q,R). Instantiate it three times.
- Everything else (bbox, cursor, output register, FSM) lives in the top.

## Test plan
- A(0,0) B(0,4) C(4,0), out_ready=1 → points (1,1), (2,1), (1,2) in that order; count=3. done 1 cycle after the last evaluation, at edge n+27 (W=H=5).
- Same triangle given as A(0,0) B(4,0) C(0,4) (reversed winding) → no out_valid, count=0, done pulses.
- Collinear A(0,0) B(2,2) C(4,4) → zero points. Also all vertices (7,7) → zero points, done at n+3.
- A(4095,0) B(4093,4095) C(4095,4095) → terminates without cursor wrap. All emitted points satisfy the area test against a bench model, and count matches the model.
- First triangle with out_ready held 0 for 5 cycles after the first point → (1,1) stable throughout, no point lost, same sequence. start pulsed while busy is ignored.
- rst asserted during SCAN → busy, out_valid, count drop immediately, no done. A new start then completes normally.
